guess_input_cond: RTL and testbench
===================================

Name: guess_input_cond

Overview:
- Upstream input stage for the guess game FSM.
- Takes the four raw push-buttons and the game run switch. Produces the synchronized, debounced button vector `b` and the single-cycle step enable `en` that the game FSM consumes.
- Also emits per-button press pulses for downstream score logic.
- Sits between the board pins and the game FSM, in the same clock domain.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles a synchronized button must hold a new level before `b` changes. Legal range 1..65535.
- TICK_DIV, 8: clock cycles per `en` pulse while running. Legal range 2..2^24.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset. 0 clears all state immediately; release is sampled on clk.
- btn_raw  input  4  raw buttons, asynchronous to clk, 1 = pressed, may bounce.
- run  input  1  game run switch (level); 1 = generate step ticks.
- b  output  4  debounced button levels, 1 = pressed; drives game FSM `b`.
- en  output  1  one-cycle step pulse; drives game FSM `en`.
- press  output  4  one-cycle pulse per bit on each debounced 0->1 transition of `b`.
- tick_cnt  output  $clog2(TICK_DIV)  current prescaler value, for debug and bench.

Behaviour:
- Reset (reset=0, async): sync flops, debounce counters, `b`, `press`, `en` and `tick_cnt` all go to 0. No pulse is emitted on reset release.
- Synchronizer:
  - Two flops per bit. `s2[i]` is `btn_raw[i]` delayed 2 edges.
  - Nothing downstream sees `btn_raw` directly.
- Debounce, per bit, independent:
  - State is the stable level `b[i]` plus a counter `cnt[i]`, width $clog2(DEBOUNCE_CYCLES+1).
  - If `s2[i] == b[i]`: `cnt[i]` <= 0.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`: `b[i]` <= `s2[i]` and `cnt[i]` <= 0.
  - Else: `cnt[i]` <= `cnt[i]+1`.
  - A bounce back to `b[i]` before the threshold restarts the count from 0.
  - Latency: a clean level change on `btn_raw` first captured at edge k appears on `b` after edge k+1+DEBOUNCE_CYCLES.
  - The same latency applies to press and release.
- Press pulses:
  - `press[i]` = 1 in exactly the cycle following the edge where `b[i]` goes 0->1 (registered alongside `b`); 0 otherwise.
  - Release produces no pulse.
  - Simultaneous presses on several bits give simultaneous pulses.
- Tick generator:
  - `tick_cnt` runs 0..TICK_DIV-1.
  - Advance condition: run=1 AND `b`==4'b0000.
  - Advance condition true: if `tick_cnt` == TICK_DIV-1, `tick_cnt` <= 0 and `en` <= 1 for one cycle; otherwise `tick_cnt` <= `tick_cnt`+1 and `en` <= 0.
  - Advance condition false: `tick_cnt` holds its value and `en` <= 0.
  - Freezing while any button is held keeps the game LED from stepping during a guess. Counting resumes from the held value once `b` returns to 0.
  - `en` is registered: first pulse after run rises comes TICK_DIV edges later from `tick_cnt`=0. Pulse period is exactly TICK_DIV cycles while unobstructed.
  - run deassert in the same cycle the counter would wrap: no `en` pulse, `tick_cnt` stays at TICK_DIV-1.
- Reset mid-press or mid-count:
  - Everything clears.
  - A button still held after release is re-debounced from 0 and produces a fresh `press` pulse.

Test Plan (DEBOUNCE_CYCLES=4, TICK_DIV=8, 10 ns clk):
- Reset: hold reset=0 for 2 cycles with btn_raw=4'b1111 and run=1 -> b=0, en=0, press=0, tick_cnt=0 throughout reset and on the first edge after release.
- Free run: run=1, btn_raw=0 for 40 cycles -> en high for exactly 1 cycle every 8 cycles, first pulse 8 edges after release; tick_cnt cycles 0..7; run=0 freezes tick_cnt and holds en=0.
- Clean press: btn_raw=4'b0001 at edge k, held 10 cycles -> b=4'b0001 after edge k+5, press=4'b0001 for that one cycle only; release -> b=0 after 5 edges, no press pulse.
- Bounce: btn_raw[2] toggles 1,0,1,0,1 on consecutive cycles, then holds 1 -> b[2] stays 0 during bouncing; rises exactly 5 edges after the final 0->1; exactly one press[2] pulse.
- Tick freeze: at tick_cnt=5 press btn 3 through to b[3]=1, hold 20 cycles -> tick_cnt stays 5 and en=0 throughout; after b returns to 0, en pulses after tick_cnt reaches 7.
- Simultaneous and reset-mid-press: btn_raw=4'b1010 -> b=4'b1010 and press=4'b1010 in the same cycle; pulse reset low while held -> b=0 at once; after release b=4'b1010 again 5 edges later with a new press pulse.

Source files
------------

// File: rtl/guess_input_cond.sv
// Input conditioning for the guess game: 2-flop button synchronizer, per-bit debounce
// with press pulses, and a run-gated step prescaler that freezes while any button is held.
module guess_input_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TICK_DIV        = 8,
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1),
  localparam int unsigned TW = $clog2(TICK_DIV)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    btn_raw,
  input  logic          run,
  output logic [3:0]    b,
  output logic          en,
  output logic [3:0]    press,
  output logic [TW-1:0] tick_cnt
);

  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [3:0]    r_s1;
  logic [3:0]    r_s2;
  logic [3:0]    r_b;
  logic [3:0]    r_press;
  logic          r_en;
  logic [TW-1:0] r_tick;
  logic [CW-1:0] r_cnt     [4];
  logic [CW-1:0] w_cnt_nxt [4];
  logic [3:0]    w_b_nxt;
  logic          w_adv;

  // Two-stage synchronizer; nothing else looks at btn_raw.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1 <= 4'b0000;
      r_s2 <= 4'b0000;
    end else begin
      r_s1 <= btn_raw;
      r_s2 <= r_s1;
    end
  end

  // Per-bit debounce next state; any return to the stable level restarts the count.
  always_comb begin
    w_b_nxt = r_b;
    for (int i = 0; i < 4; i++) begin
      w_cnt_nxt[i] = {CW{1'b0}};
      if (r_s2[i] == r_b[i]) begin
        w_cnt_nxt[i] = {CW{1'b0}};
      end else if (r_cnt[i] == DB_LAST) begin
        w_b_nxt[i]   = r_s2[i];
        w_cnt_nxt[i] = {CW{1'b0}};
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + CW'(1);
      end
    end
  end

  // Stable levels, counters and rising-edge pulses registered together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_b     <= 4'b0000;
      r_press <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= {CW{1'b0}};
      end
    end else begin
      r_b     <= w_b_nxt;
      r_press <= w_b_nxt & ~r_b;
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign w_adv = run & (r_b == 4'b0000);

  // Step prescaler: holds its value while stopped or while a button is down.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick <= {TW{1'b0}};
      r_en   <= 1'b0;
    end else if (w_adv) begin
      if (r_tick == TICK_LAST) begin
        r_tick <= {TW{1'b0}};
        r_en   <= 1'b1;
      end else begin
        r_tick <= r_tick + TW'(1);
        r_en   <= 1'b0;
      end
    end else begin
      r_tick <= r_tick;
      r_en   <= 1'b0;
    end
  end

  assign b        = r_b;
  assign press    = r_press;
  assign en       = r_en;
  assign tick_cnt = r_tick;

endmodule

// File: tb/tb_guess_input_cond.sv
// Directed bench for guess_input_cond (DEBOUNCE_CYCLES=4, TICK_DIV=8): a cycle table for
// press/bounce sequences plus hand-written reset, free-run, freeze and reset-mid-press runs.
module tb_guess_input_cond;

  logic       clk;
  logic       reset;
  logic [3:0] btn_raw;
  logic       run;
  logic [3:0] b;
  logic       en;
  logic [3:0] press;
  logic [2:0] tick_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] btn;
    logic [3:0] eb;
    logic [3:0] ep;
    string      nm;
  } vec_t;

  vec_t tbl[$];

  guess_input_cond #(
    .DEBOUNCE_CYCLES(4),
    .TICK_DIV(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .run(run),
    .b(b),
    .en(en),
    .press(press),
    .tick_cnt(tick_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] eb, input logic [3:0] ep,
                     input logic een, input logic [2:0] et);
    n_cmp++;
    if (b !== eb || press !== ep || en !== een || tick_cnt !== et) begin
      n_fail++;
      $display("FAIL %s: got b=%b press=%b en=%b tick=%0d, want b=%b press=%b en=%b tick=%0d",
               nm, b, press, en, tick_cnt, eb, ep, een, et);
    end
  endtask

  task automatic add(input logic [3:0] btn, input logic [3:0] eb, input logic [3:0] ep,
                     input string nm, input int reps);
    vec_t v;
    for (int i = 0; i < reps; i++) begin
      v.btn = btn;
      v.eb  = eb;
      v.ep  = ep;
      v.nm  = nm;
      tbl.push_back(v);
    end
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = 4'b1111;
    run     = 1'b1;
    #2 reset = 1'b0;

    // Reset held for two edges with all buttons pressed and run high.
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("reset_hold%0d", i), 4'b0000, 4'b0000, 1'b0, 3'd0);
    end
    reset   = 1'b1;
    btn_raw = 4'b0000;
    #1;
    chk("reset_release", 4'b0000, 4'b0000, 1'b0, 3'd0);

    // Free run: pulse on every 8th edge, first one 8 edges after release.
    for (int n = 1; n <= 43; n++) begin
      step();
      chk($sformatf("free_run%0d", n), 4'b0000, 4'b0000, (n % 8) == 0, 3'(n % 8));
    end
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("run_off%0d", i), 4'b0000, 4'b0000, 1'b0, 3'd3);
    end

    // Table: clean press/release on bit 0, then bounce on bit 2 (run=0, tick held at 3).
    add(4'b0001, 4'b0000, 4'b0000, "clean_wait", 5);
    add(4'b0001, 4'b0001, 4'b0001, "clean_rise", 1);
    add(4'b0001, 4'b0001, 4'b0000, "clean_hold", 4);
    add(4'b0000, 4'b0001, 4'b0000, "clean_relwait", 5);
    add(4'b0000, 4'b0000, 4'b0000, "clean_fall", 2);
    add(4'b0100, 4'b0000, 4'b0000, "bounce_a", 1);
    add(4'b0000, 4'b0000, 4'b0000, "bounce_b", 1);
    add(4'b0100, 4'b0000, 4'b0000, "bounce_c", 1);
    add(4'b0000, 4'b0000, 4'b0000, "bounce_d", 1);
    add(4'b0100, 4'b0000, 4'b0000, "bounce_e", 5);
    add(4'b0100, 4'b0100, 4'b0100, "bounce_rise", 1);
    add(4'b0100, 4'b0100, 4'b0000, "bounce_hold", 2);
    add(4'b0000, 4'b0100, 4'b0000, "bounce_relwait", 5);
    add(4'b0000, 4'b0000, 4'b0000, "bounce_fall", 2);
    for (int i = 0; i < tbl.size(); i++) begin
      btn_raw = tbl[i].btn;
      step();
      chk($sformatf("%s@%0d", tbl[i].nm, i), tbl[i].eb, tbl[i].ep, 1'b0, 3'd3);
    end

    // Tick freeze while button 3 is held.
    run = 1'b1;
    step();
    chk("frz_adv4", 4'b0000, 4'b0000, 1'b0, 3'd4);
    step();
    chk("frz_adv5", 4'b0000, 4'b0000, 1'b0, 3'd5);
    run     = 1'b0;
    btn_raw = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("frz_wait%0d", i), 4'b0000, 4'b0000, 1'b0, 3'd5);
    end
    step();
    chk("frz_rise", 4'b1000, 4'b1000, 1'b0, 3'd5);
    run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("frz_hold%0d", i), 4'b1000, 4'b0000, 1'b0, 3'd5);
    end
    btn_raw = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("frz_relwait%0d", i), 4'b1000, 4'b0000, 1'b0, 3'd5);
    end
    step();
    chk("frz_fall", 4'b0000, 4'b0000, 1'b0, 3'd5);
    step();
    chk("frz_resume6", 4'b0000, 4'b0000, 1'b0, 3'd6);
    step();
    chk("frz_resume7", 4'b0000, 4'b0000, 1'b0, 3'd7);

    // run dropped exactly where the counter would wrap.
    run = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("wrap_blocked%0d", i), 4'b0000, 4'b0000, 1'b0, 3'd7);
    end
    run = 1'b1;
    step();
    chk("wrap_pulse", 4'b0000, 4'b0000, 1'b1, 3'd0);
    step();
    chk("wrap_after", 4'b0000, 4'b0000, 1'b0, 3'd1);

    // Simultaneous press on bits 3 and 1, then reset while still held.
    run     = 1'b0;
    btn_raw = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("sim_wait%0d", i), 4'b0000, 4'b0000, 1'b0, 3'd1);
    end
    step();
    chk("sim_rise", 4'b1010, 4'b1010, 1'b0, 3'd1);
    step();
    chk("sim_hold", 4'b1010, 4'b0000, 1'b0, 3'd1);
    reset = 1'b0;
    #1;
    chk("midpress_reset", 4'b0000, 4'b0000, 1'b0, 3'd0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("redeb_wait%0d", i), 4'b0000, 4'b0000, 1'b0, 3'd0);
    end
    step();
    chk("redeb_rise", 4'b1010, 4'b1010, 1'b0, 3'd0);
    step();
    chk("redeb_hold", 4'b1010, 4'b0000, 1'b0, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
